// File: rtl/dmem_access_ctrl_if.sv
// Bus bundle for the memory-stage data-access controller: EX/MEM inputs,
// data-cache request/response, snoop channel and MEM/WB-facing results.
// The master modport is the controller's view; slave is the view of the
// surrounding pipeline and cache.
interface dmem_access_ctrl_if #(
  parameter int WAIT_W = 8,
  parameter int PERF_W = 32
);
  // EX/MEM latch
  logic              exmem_valid;
  logic              exmem_dREN;
  logic              exmem_dWEN;
  logic              exmem_ll;
  logic              exmem_sc;
  logic [31:0]       exmem_addr;
  logic [31:0]       exmem_store;
  // data cache
  logic              dhit;
  logic [31:0]       dmemload;
  logic              dmemREN;
  logic              dmemWEN;
  logic [31:0]       dmemaddr;
  logic [31:0]       dmemstore;
  // coherence snoop
  logic              snoop_inval;
  logic [31:0]       snoop_addr;
  // pipeline control and results
  logic              mem_stall;
  logic              memwb_enable;
  logic [31:0]       load_data;
  logic [31:0]       sc_result;
  logic [WAIT_W-1:0] wait_cnt;
  logic [PERF_W-1:0] stall_total;

  modport master (
    input  exmem_valid, exmem_dREN, exmem_dWEN, exmem_ll, exmem_sc,
    input  exmem_addr, exmem_store, dhit, dmemload, snoop_inval, snoop_addr,
    output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall, memwb_enable,
    output load_data, sc_result, wait_cnt, stall_total
  );

  modport slave (
    output exmem_valid, exmem_dREN, exmem_dWEN, exmem_ll, exmem_sc,
    output exmem_addr, exmem_store, dhit, dmemload, snoop_inval, snoop_addr,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall, memwb_enable,
    input  load_data, sc_result, wait_cnt, stall_total
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Memory-stage data-access controller. Issues cache requests for the
// instruction in EX/MEM, stalls the front of the pipeline until dhit, and
// presents the load word and MEM/WB enable.
// Optional load-linked / store-conditional reservation: define DMEM_LLSC_EN.
//
// Handshake: dmemREN/dmemWEN act as a request valid and dhit as its ready.
// A request is raised combinationally from EX/MEM, held unchanged until
// the cycle dhit is seen (inclusive), and the transfer completes exactly
// in that cycle; dmemload is only meaningful while dhit is high.
module dmem_access_ctrl #(
  parameter int WAIT_W = 8,
  parameter int PERF_W = 32
) (
  input  logic          CLK,
  input  logic          RST,
  dmem_access_ctrl_if.master bus,
  output logic          dbgWait   // 1 while the FSM sits in WAIT
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t            state;
  state_t            stateNext;
  logic              op;
  logic              scFail;
  logic              memStall;
  logic [31:0]       loadQ;
  logic [WAIT_W-1:0] waitCnt;
  logic [PERF_W-1:0] stallTotal;

`ifdef DMEM_LLSC_EN
  logic        linkValid;
  logic [29:0] linkAddr;
  logic        snoopHit;
  logic        llDone;
  logic        scDone;
  logic        unusedAddrLsb;

  // A snoop on the linked word in the same cycle as the SC wins over it.
  assign snoopHit = bus.snoop_inval & (bus.snoop_addr[31:2] == linkAddr);
  assign scFail   = bus.exmem_sc &
                    ~(linkValid & (linkAddr == bus.exmem_addr[31:2]) & ~snoopHit);
  assign llDone   = op & bus.exmem_dREN & bus.exmem_ll & bus.dhit;
  // Any SC consumes the link: a failing one at once, a passing one on dhit.
  assign scDone   = bus.exmem_valid & bus.exmem_sc & (scFail | bus.dhit);
  assign bus.sc_result = {31'b0, bus.exmem_valid & bus.exmem_sc & ~scFail & bus.dhit};
  assign unusedAddrLsb = ^{bus.exmem_addr[1:0], bus.snoop_addr[1:0]};

  // Reservation register; an LL completion outranks a same-cycle snoop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      linkValid <= 1'b0;
      linkAddr  <= '0;
    end else if (llDone) begin
      linkValid <= 1'b1;
      linkAddr  <= bus.exmem_addr[31:2];
    end else if (scDone | snoopHit) begin
      linkValid <= 1'b0;
    end
  end
`else
  logic unusedInputs;

  // Without the reservation LL is a plain load and SC a plain store that
  // always reports success.
  assign scFail        = 1'b0;
  assign bus.sc_result = {31'b0, bus.exmem_sc};
  assign unusedInputs  = ^{bus.exmem_ll, bus.snoop_inval, bus.snoop_addr,
                           bus.exmem_addr[1:0]};
`endif

  assign op       = bus.exmem_valid & (bus.exmem_dREN | bus.exmem_dWEN) & ~scFail;
  assign memStall = op & ~bus.dhit;

  // Requests and pipeline control are purely combinational on EX/MEM.
  assign bus.dmemREN      = op & bus.exmem_dREN;
  assign bus.dmemWEN      = op & bus.exmem_dWEN;
  assign bus.dmemaddr     = {bus.exmem_addr[31:2], 2'b00};
  assign bus.dmemstore    = bus.exmem_store;
  assign bus.mem_stall    = memStall;
  assign bus.memwb_enable = ~memStall;
  assign bus.load_data    = bus.dhit ? bus.dmemload : loadQ;
  assign bus.wait_cnt     = waitCnt;
  assign bus.stall_total  = stallTotal;
  assign dbgWait          = (state == WAIT);

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state: leave IDLE on an unanswered access, leave WAIT only on dhit.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (op & ~bus.dhit) stateNext = WAIT;
      WAIT:    if (bus.dhit)       stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Hold the last loaded word so load_data stays stable outside dhit.
  always_ff @(posedge CLK) begin
    if (RST)                            loadQ <= '0;
    else if (bus.dhit & bus.dmemREN)    loadQ <= bus.dmemload;
  end

  // Per-access wait counter: counts stall cycles, clears otherwise, saturates.
  always_ff @(posedge CLK) begin
    if (RST)                 waitCnt <= '0;
    else if (!memStall)      waitCnt <= '0;
    else if (waitCnt != '1)  waitCnt <= waitCnt + 1'b1;
  end

  // Cumulative stall-cycle counter, saturating.
  always_ff @(posedge CLK) begin
    if (RST)                                 stallTotal <= '0;
    else if (memStall && stallTotal != '1)   stallTotal <= stallTotal + 1'b1;
  end

endmodule
